// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Resolves the oldest entry against
// the execute outcome, emits a registered training packet and flushes on mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int GHR_W = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_taken,
    input  logic [GHR_W-1:0]           pred_ghr,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic [GHR_W-1:0]           upd_ghr,
    output logic                       correct,
    output logic                       mispredict,
    output logic [GHR_W-1:0]           restore_ghr,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic             taken_mem [DEPTH];
    logic [GHR_W-1:0] ghr_mem   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_n;
    logic             push;
    logic             pop;
    logic             hit;

    // Handshake: a push is taken on any edge where pred_valid && pred_ready; pred_ready
    // depends only on the registered count, so a same-cycle pop never frees a slot for
    // a push. res_valid has no ready: it is simply ignored while the queue is empty.
    assign pred_ready = (count != CNT_W'(DEPTH));
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && (count != '0);
    assign hit        = (res_taken == taken_mem[head]);

    always_comb begin
        count_n = count;
        if (push && !pop)
            count_n = count + CNT_W'(1);
        else if (!push && pop)
            count_n = count - CNT_W'(1);
    end

    // Entry storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[tail]    <= pred_pc;
            taken_mem[tail] <= pred_taken;
            ghr_mem[tail]   <= pred_ghr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (pop && !hit) begin
            // Everything younger than the mispredicted branch is wrong-path, including
            // a push landing on this same edge.
            head  <= head + PTR_W'(1);
            tail  <= head + PTR_W'(1);
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            count <= count_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upd_valid   <= 1'b0;
            correct     <= 1'b0;
            mispredict  <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_ghr     <= '0;
            restore_ghr <= '0;
        end else begin
            upd_valid  <= pop;
            correct    <= pop && hit;
            mispredict <= pop && !hit;
            if (pop) begin
                upd_pc      <= pc_mem[head];
                upd_taken   <= res_taken;
                upd_ghr     <= ghr_mem[head];
                restore_ghr <= {ghr_mem[head][GHR_W-2:0], res_taken};
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus a randomized run, all
// checked against a queue-based model of the in-flight branch list.
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int GHR_W = 12;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             pred_valid = 1'b0;
    logic [PC_W-1:0]  pred_pc = '0;
    logic             pred_taken = 1'b0;
    logic [GHR_W-1:0] pred_ghr = '0;
    logic             pred_ready;
    logic             res_valid = 1'b0;
    logic             res_taken = 1'b0;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [GHR_W-1:0] upd_ghr;
    logic             correct;
    logic             mispredict;
    logic [GHR_W-1:0] restore_ghr;
    logic [CNT_W-1:0] count;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .GHR_W(GHR_W)) dut (
        .clock(clock), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_ghr(pred_ghr), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_ghr(upd_ghr), .correct(correct), .mispredict(mispredict),
        .restore_ghr(restore_ghr), .count(count)
    );

    always #5 clock = ~clock;

    // Reference model: program-ordered list of outstanding predictions.
    logic [PC_W-1:0]  exp_q[$];
    logic             exp_tk_q[$];
    logic [GHR_W-1:0] exp_gh_q[$];

    logic             exp_uv, exp_cor, exp_mis, exp_tk;
    logic [PC_W-1:0]  exp_pc;
    logic [GHR_W-1:0] exp_gh, exp_rg;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_clear();
        exp_q.delete(); exp_tk_q.delete(); exp_gh_q.delete();
        exp_uv = 0; exp_cor = 0; exp_mis = 0; exp_tk = 0;
        exp_pc = '0; exp_gh = '0; exp_rg = '0;
    endtask

    // Drives one cycle of stimulus, advances the model, returns #1 after the edge.
    task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic pt,
                        input logic [GHR_W-1:0] pg, input logic rv, input logic rt);
        logic ready, pop;
        @(negedge clock);
        pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_ghr = pg;
        res_valid = rv; res_taken = rt;
        ready = (exp_q.size() < DEPTH);
        pop = rv && (exp_q.size() > 0);
        exp_uv = pop; exp_cor = 0; exp_mis = 0;
        if (pop) begin
            exp_pc = exp_q.pop_front();
            exp_gh = exp_gh_q.pop_front();
            exp_cor = (exp_tk_q.pop_front() == rt);
            exp_mis = !exp_cor;
            exp_tk = rt;
            exp_rg = {exp_gh[GHR_W-2:0], rt};
        end
        if (pop && exp_mis) begin
            exp_q.delete(); exp_tk_q.delete(); exp_gh_q.delete();
        end else if (pv && ready) begin
            exp_q.push_back(pc); exp_tk_q.push_back(pt); exp_gh_q.push_back(pg);
        end
        @(posedge clock);
        #1;
        pred_valid = 0; res_valid = 0;
    endtask

    task automatic do_reset(input logic rv);
        @(negedge clock);
        reset = 1; res_valid = rv; res_taken = 0;
        @(posedge clock);
        #1;
        reset = 0; res_valid = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset(0);
        n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_upd_valid got %b want 0", upd_valid); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (pred_ready !== 1'b1) begin n_bad++; $display("FAIL reset_pred_ready got %b want 1", pred_ready); end
        n_cmp++; if ({correct, mispredict} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {correct, mispredict}); end
        n_cmp++; if (upd_pc !== '0 || upd_ghr !== '0 || restore_ghr !== '0) begin
            n_bad++; $display("FAIL reset_data got pc=%h ghr=%h rg=%h want 0", upd_pc, upd_ghr, restore_ghr); end
    endtask

    task automatic test_single_correct();
        do_reset(0);
        step(1, 32'h100, 1, 12'h0A5, 0, 0);
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL single_count_push got %0d want 1", count); end
        step(0, 0, 0, 0, 1, 1);
        n_cmp++; if ({upd_valid, correct, mispredict} !== 3'b110) begin
            n_bad++; $display("FAIL single_flags got %b want 110", {upd_valid, correct, mispredict}); end
        n_cmp++; if (upd_pc !== 32'h100 || upd_ghr !== 12'h0A5 || upd_taken !== 1'b1) begin
            n_bad++; $display("FAIL single_data got pc=%h ghr=%h tk=%b want 100/0a5/1", upd_pc, upd_ghr, upd_taken); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL single_count got %0d want 0", count); end
        step(0, 0, 0, 0, 0, 0);
        n_cmp++; if (upd_valid !== 1'b0 || upd_pc !== 32'h100) begin
            n_bad++; $display("FAIL single_hold got uv=%b pc=%h want 0/100", upd_valid, upd_pc); end
    endtask

    task automatic test_mispredict();
        do_reset(0);
        step(1, 32'h100, 1, 12'h3C1, 0, 0);
        step(1, 32'h104, 1, 12'h001, 0, 0);
        step(1, 32'h108, 1, 12'h002, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        n_cmp++; if ({upd_valid, correct, mispredict} !== 3'b101) begin
            n_bad++; $display("FAIL mis_flags got %b want 101", {upd_valid, correct, mispredict}); end
        n_cmp++; if (restore_ghr !== 12'h782 || upd_pc !== 32'h100) begin
            n_bad++; $display("FAIL mis_restore got rg=%h pc=%h want 782/100", restore_ghr, upd_pc); end
        n_cmp++; if (count !== '0 || pred_ready !== 1'b1) begin
            n_bad++; $display("FAIL mis_count got %0d rdy=%b want 0/1", count, pred_ready); end
        step(0, 0, 0, 0, 1, 1);
        n_cmp++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) begin
            n_bad++; $display("FAIL mis_flushed got uv=%b mis=%b want 0/0", upd_valid, mispredict); end
    endtask

    task automatic test_full_drain();
        logic tk[DEPTH];
        do_reset(0);
        // Start pointers off zero so the drain wraps.
        step(1, 32'hAA0, 0, 12'h0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            tk[i] = 1'($urandom_range(0, 1));
            step(1, 32'h300 + 32'(4 * i), tk[i], GHR_W'(i), 0, 0);
        end
        n_cmp++; if (pred_ready !== 1'b0 || count !== 4'd8) begin
            n_bad++; $display("FAIL full_state got rdy=%b cnt=%0d want 0/8", pred_ready, count); end
        step(1, 32'hDEAD, 1, 12'hFFF, 0, 0);
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_drop got %0d want 8", count); end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 1, tk[i]);
            n_cmp++; if (upd_valid !== 1'b1 || correct !== 1'b1 || upd_pc !== 32'h300 + 32'(4 * i)) begin
                n_bad++; $display("FAIL drain_%0d got uv=%b cor=%b pc=%h want 1/1/%h", i, upd_valid, correct, upd_pc, 32'h300 + 32'(4 * i)); end
        end
        n_cmp++; if (pred_ready !== 1'b1 || count !== '0) begin
            n_bad++; $display("FAIL drain_end got rdy=%b cnt=%0d want 1/0", pred_ready, count); end
    endtask

    task automatic test_simultaneous();
        do_reset(0);
        step(1, 32'h180, 1, 12'h010, 0, 0);
        step(1, 32'h184, 1, 12'h020, 0, 0);
        step(1, 32'h200, 1, 12'h030, 1, 1);
        n_cmp++; if (count !== 4'd2 || upd_pc !== 32'h180 || correct !== 1'b1) begin
            n_bad++; $display("FAIL simul_hit got cnt=%0d pc=%h cor=%b want 2/180/1", count, upd_pc, correct); end
        step(1, 32'h204, 1, 12'h040, 1, 0);
        n_cmp++; if (count !== '0 || mispredict !== 1'b1 || upd_pc !== 32'h184) begin
            n_bad++; $display("FAIL simul_mis got cnt=%0d mis=%b pc=%h want 0/1/184", count, mispredict, upd_pc); end
        step(0, 0, 0, 0, 1, 1);
        n_cmp++; if (upd_valid !== 1'b0 || count !== '0) begin
            n_bad++; $display("FAIL simul_discard got uv=%b cnt=%0d want 0/0", upd_valid, count); end
    endtask

    task automatic test_empty_resolve();
        do_reset(0);
        step(0, 0, 0, 0, 1, 1);
        n_cmp++; if (upd_valid !== 1'b0 || count !== '0) begin
            n_bad++; $display("FAIL empty_res got uv=%b cnt=%0d want 0/0", upd_valid, count); end
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        step(1, 32'h400, 1, 12'h1, 0, 0);
        step(1, 32'h404, 0, 12'h2, 0, 0);
        // Resolve requested on the same edge reset is sampled: the packet must not appear.
        do_reset(1);
        n_cmp++; if (upd_valid !== 1'b0 || count !== '0 || pred_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid got uv=%b cnt=%0d rdy=%b want 0/0/1", upd_valid, count, pred_ready); end
        step(0, 0, 0, 0, 0, 0);
        n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_after got %b want 0", upd_valid); end
    endtask

    task automatic test_random();
        do_reset(0);
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 1)), GHR_W'($urandom),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 85));
            n_cmp++;
            if (upd_valid !== exp_uv || correct !== exp_cor || mispredict !== exp_mis ||
                count !== CNT_W'(exp_q.size()) || pred_ready !== (exp_q.size() != DEPTH) ||
                upd_pc !== exp_pc || upd_ghr !== exp_gh || upd_taken !== exp_tk || restore_ghr !== exp_rg) begin
                n_bad++;
                $display("FAIL rand_%0d got uv=%b cor=%b mis=%b cnt=%0d pc=%h ghr=%h tk=%b rg=%h want %b/%b/%b/%0d/%h/%h/%b/%h",
                         c, upd_valid, correct, mispredict, count, upd_pc, upd_ghr, upd_taken, restore_ghr,
                         exp_uv, exp_cor, exp_mis, exp_q.size(), exp_pc, exp_gh, exp_tk, exp_rg);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_correct();
        test_mispredict();
        test_full_drain();
        test_simultaneous();
        test_empty_resolve();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
